fft_io_controller: RTL
======================

# fft_io_controller

Frame-level sequencer that shares the FFT sample memory between the external streaming interface and the compute driver. It loads N input samples from a valid/ready stream into the memory in bit-reversed address order, then hands the frame to the compute driver with a single-cycle `input_valid` and releases the memory port. It waits for `fft_done` and then streams the N results out in natural order. `io_busy` tells the compute driver when the IO side owns the memory.

## Interface
- `N`, 32, FFT length; power of two, ≥4
- `DATA_WIDTH`, 32, packed complex sample width (re in upper half)
- `ADDR_WIDTH`, $clog2(N), memory address width
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `s_valid`  in  1  input sample valid
- `s_data`  in  DATA_WIDTH  input sample
- `s_ready`  out  1  controller accepts input sample
- `m_valid`  out  1  output sample valid
- `m_data`  out  DATA_WIDTH  output sample
- `m_last`  out  1  marks sample N-1 of the output frame
- `m_ready`  in  1  downstream accepts output sample
- `input_valid`  out  1  one-cycle frame-ready pulse to the compute driver
- `io_busy`  out  1  IO side owns the memory port
- `fft_busy`  in  1  compute driver busy
- `fft_done`  in  1  one-cycle compute-complete pulse
- `mem_en`  out  1  memory port enable from IO side
- `mem_we`  out  1  write strobe
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  write data
- `mem_rdata`  in  DATA_WIDTH  read data, valid exactly 1 cycle after a read (`mem_en & !mem_we`)
- `seq_err`  out  1  sticky: `fft_done` seen outside WAIT, or `fft_busy` low in WAIT without `fft_done`

## Operation
- States: LOAD, START, WAIT, UNLOAD. Reset state is LOAD.
- LOAD
  - `s_ready`=1, `io_busy`=1.
  - Each `s_valid & s_ready` writes `s_data` to `mem_addr`=bitrev(`load_cnt`) with `mem_en`=`mem_we`=1, then increments `load_cnt`.
  - On the accept with `load_cnt`==N-1, go to START and clear `load_cnt`.
- START
  - `io_busy`=0, `mem_en`=0, `input_valid`=1 for exactly this one cycle.
  - Next state is WAIT unconditionally.
- WAIT
  - `io_busy`=0, `mem_en`=0.
  - On `fft_done`, go to UNLOAD.
  - `fft_busy` must be high from the second WAIT cycle until `fft_done`. If it is not, set `seq_err`; the state does not change.
- UNLOAD
  - `io_busy`=1, `s_ready`=0.
  - Read addresses `rd_cnt`=0..N-1 in natural order into a 2-entry output FIFO.
  - A read is issued when (FIFO occupancy + read-in-flight) < 2 and `rd_cnt` < N.
  - `m_valid` = FIFO not empty. `m_last` = head entry is index N-1.
  - After the `m_last` handshake, go to LOAD with `rd_cnt` cleared.
- `bitrev` reverses the ADDR_WIDTH bits. For N=8: 1→4, 3→6, 6→3.
- Counters are ADDR_WIDTH+1 bits wide so that N is representable.
- `fft_done` in LOAD, START or UNLOAD is ignored for sequencing and sets `seq_err`.
- Reset mid-operation:
  - State returns to LOAD; counters, FIFO and in-flight flag clear.
  - A partially loaded or unloaded frame is discarded.
  - `seq_err` clears only on reset.

## Timing
- Reset values: `s_ready`=1, `io_busy`=1, `m_valid`=0, `m_last`=0, `input_valid`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `seq_err`=0.
- Memory outputs (`mem_en`, `mem_we`, `mem_addr`, `mem_wdata`) are combinational from state, counters and `s_valid`.
- `m_*` are driven from FIFO registers.
- Load throughput: 1 sample/cycle with `s_valid` held high. The N-th accept is followed by START on the next cycle.
- START→WAIT is 1 cycle. The compute driver samples `input_valid & !io_busy` in START and raises `fft_busy` in the first WAIT cycle.
- UNLOAD latency:
  - First read is issued in the first UNLOAD cycle.
  - First `m_valid` is 2 cycles after entering UNLOAD.
  - With `m_ready` held high, 1 sample/cycle; the last sample appears N+1 cycles after UNLOAD entry.
- Backpressure: `m_data`/`m_last` stay stable while `m_valid & !m_ready`. No sample is dropped or duplicated. A read already in flight always lands in a free FIFO slot.
- Frame turnaround: the cycle after the `m_last` handshake, `s_ready`=1.

## Structure
- Shared package `fft_pkg`:
  - io state enum constants (LOAD=2'd0, START=2'd1, WAIT=2'd2, UNLOAD=2'd3)
  - `bitrev` function, parameterised on ADDR_WIDTH
- Sub-module `fft_out_fifo2`: 2-entry FIFO of {last, data} with push, pop, full, empty and count, reset to empty.
- Everything else is in one always block for state/counters plus combinational memory-port decode.

## Test plan
- N=8, load samples 0x10..0x17 back-to-back → writes to addresses 0,4,2,6,1,5,3,7 in that order; START for one cycle with `input_valid`=1, `io_busy`=0.
- In WAIT, `fft_done` pulse after 40 cycles with `mem_rdata`=addr+0x100 → `m_data` 0x100..0x107 in order, first `m_valid` 2 cycles after UNLOAD entry, `m_last` on 0x107.
- During unload, toggle `m_ready` 1,0,0,1 repeatedly → all 8 outputs delivered once each in order, stable while stalled, FIFO never overflows.
- Assert `reset` after 5 of 8 load samples → all outputs at reset values; next 8 samples load starting at address 0.
- `fft_done` pulse in LOAD → no state change, `seq_err`=1 and held until reset.
- Two consecutive frames with `s_valid`/`m_ready` always high → second frame's `s_ready` rises the cycle after the first `m_last` handshake; both outputs correct.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT IO sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } io_state_t;

  localparam int unsigned BITREV_MAX_W = 16;

  // Reverse the low w bits of a; bits at and above w return zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] a,
                                                      input int unsigned w);
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(BITREV_MAX_W); i++) begin
      if (i < int'(w)) r[4'(i)] = a[4'(int'(w) - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_fifo2.sv
// Two-entry output FIFO holding {last, data} for the unload stream.
module fft_out_fifo2 #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] ent0, ent1;
  logic         wr_ptr, rd_ptr;
  logic [1:0]   cnt;
  logic         do_push, do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  // Entry storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent0   <= '0;
      ent1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr) ent1 <= din;
        else        ent0 <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end

  assign dout  = rd_ptr ? ent1 : ent0;
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule

// File: rtl/fft_io_controller.sv
// Frame sequencer sharing the FFT sample memory between streaming IO and compute.
module fft_io_controller
  import fft_pkg::*;
#(
  parameter int N          = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  input_valid,
  output logic                  io_busy,
  input  logic                  fft_busy,
  input  logic                  fft_done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  seq_err
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  io_state_t         state, state_nx;
  logic [CW-1:0]     load_cnt, rd_cnt;
  logic              rd_inflight, rd_inflight_last;
  logic              wait_first;
  logic              accept, pop, rd_room, rd_issue;
  logic              fifo_full, fifo_empty;
  logic [1:0]        fifo_count;
  logic [DATA_WIDTH:0] fifo_dout;

  assign accept  = (state == LOAD) && s_valid;
  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;

  // Room for one more read counting the slot freed by a pop this cycle.
  assign rd_room  = pop ? !(fifo_full && rd_inflight)
                        : ((fifo_count + 2'(rd_inflight)) < 2'd2);
  assign rd_issue = (state == UNLOAD) && (rd_cnt < CW'(N)) && rd_room;

  fft_out_fifo2 #(.W(DATA_WIDTH + 1)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rd_inflight),
    .pop   (pop),
    .din   ({rd_inflight_last, mem_rdata}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_last = fifo_dout[DATA_WIDTH];
  assign m_data = fifo_dout[DATA_WIDTH-1:0];

  // State, counters, read-in-flight tracking and sticky sequencing error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= LOAD;
      load_cnt         <= '0;
      rd_cnt           <= '0;
      rd_inflight      <= 1'b0;
      rd_inflight_last <= 1'b0;
      wait_first       <= 1'b0;
      seq_err          <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        load_cnt <= (load_cnt == CW'(N - 1)) ? '0 : load_cnt + CW'(1);
      end
      rd_inflight      <= rd_issue;
      rd_inflight_last <= rd_issue && (rd_cnt == CW'(N - 1));
      if ((state == UNLOAD) && pop && m_last) rd_cnt <= '0;
      else if (rd_issue)                      rd_cnt <= rd_cnt + CW'(1);
      wait_first <= (state == START);
      if ((fft_done && (state != WAIT)) ||
          ((state == WAIT) && !wait_first && !fft_busy && !fft_done)) begin
        seq_err <= 1'b1;
      end
    end
  end

  // Next-state and combinational memory-port / handshake decode.
  always_comb begin
    state_nx    = state;
    s_ready     = 1'b0;
    io_busy     = 1'b0;
    input_valid = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        io_busy = 1'b1;
        if (s_valid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ADDR_WIDTH'(bitrev(BITREV_MAX_W'(load_cnt[ADDR_WIDTH-1:0]), ADDR_WIDTH));
          mem_wdata = s_data;
          if (load_cnt == CW'(N - 1)) state_nx = START;
        end
      end
      START: begin
        input_valid = 1'b1;
        state_nx    = WAIT;
      end
      WAIT: begin
        if (fft_done) state_nx = UNLOAD;
      end
      UNLOAD: begin
        io_busy = 1'b1;
        if (rd_issue) begin
          mem_en   = 1'b1;
          mem_addr = rd_cnt[ADDR_WIDTH-1:0];
        end
        if (pop && m_last) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

endmodule
